fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of instruction memory and feeding the decode stage. It owns the program counter and drives the word address to instruction memory. It captures the combinational read data into the IF/ID pipeline register. It also applies hazard-unit stalls and branch redirect/flush, and keeps saturating stall/flush event counters.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage_ifid_reg.sv | 40 ++++
 rtl/fetch_stage.sv | 82 ++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants and types for the fetch stage and its IF/ID register.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // sll $0,$0,0 -- the canonical bubble instruction
  localparam word_t NOP    = 32'h0000_0000;
  localparam word_t PC_INC = 32'd4;

  // Clear the byte-offset bits so a redirect always lands on a word boundary
  function automatic word_t word_align(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus: fetch stage drives the address, memory answers combinationally.
interface fetch_stage_if;

  fetch_stage_pkg::word_t imem_addr;
  fetch_stage_pkg::word_t imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with flush (bubble), hold and in-range load controls.
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  hold,
  input  logic  in_range,
  input  word_t instr_in,
  input  word_t pc4_in,
  output word_t instr,
  output word_t pc4,
  output logic  valid
);

  // Flush beats hold; an unheld out-of-range fetch also turns into a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      if (in_range) begin
        instr <= instr_in;
        pc4   <= pc4_in;
        valid <= 1'b1;
      end else begin
        instr <= NOP;
        pc4   <= '0;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, fills IF/ID,
// and tracks sticky fetch faults plus saturating stall/flush event counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    IMEM_WORDS = 1024,
  parameter int    CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  word_t            branch_target,
  fetch_stage_if.master    imem,
  output word_t            pc,
  output word_t            ifid_instr,
  output word_t            ifid_pc4,
  output logic             ifid_valid,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  word_t pc_p0;
  word_t pc4_p0;
  logic  in_range_p0;
  logic  misaligned_p0;
  logic  oor_fetch_p0;

  assign pc             = pc_p0;
  assign imem.imem_addr = pc_p0;
  assign pc4_p0         = pc_p0 + PC_INC;
  assign in_range_p0    = ({2'b00, pc_p0[XLEN-1:2]} < word_t'(IMEM_WORDS));
  assign misaligned_p0  = branch_taken && (branch_target[1:0] != 2'b00);
  // Only an actual (unstalled, unflushed) fetch past the end of memory is a fault
  assign oor_fetch_p0   = !branch_taken && !stall && !in_range_p0;

  // Next PC: redirect, else hold on stall, else sequential with natural 2^32 wrap
  always_ff @(posedge clk) begin
    if (reset)             pc_p0 <= RESET_PC;
    else if (branch_taken) pc_p0 <= word_align(branch_target);
    else if (!stall)       pc_p0 <= pc4_p0;
  end

  // Fault is sticky until reset and never blocks fetching
  always_ff @(posedge clk) begin
    if (reset)                             fetch_fault <= 1'b0;
    else if (misaligned_p0 || oor_fetch_p0) fetch_fault <= 1'b1;
  end

  // Event counters saturate at all-ones; a flush cycle is not counted as a stall
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (branch_taken) begin
      flush_cnt <= sat_inc(flush_cnt);
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // ---- IF -> ID boundary ----
  fetch_stage_ifid_reg u_ifid (
    .clk      (clk),
    .rst      (reset),
    .flush    (branch_taken),
    .hold     (stall),
    .in_range (in_range_p0),
    .instr_in (imem.imem_data),
    .pc4_in   (pc4_p0),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .valid    (ifid_valid)
  );

endmodule
